ip_rom_arbiter: RTL

- Shares the single-port boot/IPL ROM between two bus masters: port 0 is the Z80 CPU bus and port 1 is the loader/DMA engine.
- Drives the ROM's chip-select, read strobe and address, and waits for the ROM's one-cycle-late `rdata_en`.
- Returns the byte to the granted requester with a one-cycle ack.
- Sits between the requesters and the ROM instance on the same clock.

---
 rtl/ip_rom_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/ip_rom_arbiter.sv
// ip_rom_arbiter: shares one boot ROM between two read ports, round-robin by default
// or fixed port-0 priority when IP_ROM_ARB_FIXED_PRIORITY_EN is defined.
module ip_rom_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] address0,
  output logic              ack0,
  output logic [7:0]        rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] address1,
  output logic              ack1,
  output logic [7:0]        rdata1,
  output logic              rom_n_cs,
  output logic              rom_n_rd,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [7:0]        rom_rdata,
  input  logic              rom_rdata_en,
  output logic              busy,
  output logic              timeout_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [3:0] LAST = 4'(TIMEOUT - 1);
  state_t     state;
  logic       grant;
  logic       win;
  logic [3:0] cnt;
  logic       fin;
  logic [7:0] dat;
`ifdef IP_ROM_ARB_FIXED_PRIORITY_EN
  assign win = !req0;
`else
  logic last_grant;
  assign win = (req0 && req1) ? !last_grant : req1;
`endif
  // a missing rdata_en after the last allowed WAIT cycle completes with 0xFF
  assign fin = rom_rdata_en || cnt == LAST;
  assign dat = rom_rdata_en ? rom_rdata : 8'hFF;
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= IDLE;
      grant       <= 1'b0;
      cnt         <= 4'd0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= 8'h00;
      rdata1      <= 8'h00;
      rom_n_cs    <= 1'b1;
      rom_n_rd    <= 1'b1;
      rom_address <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
`ifndef IP_ROM_ARB_FIXED_PRIORITY_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: if (req0 || req1) begin
          grant       <= win;
`ifndef IP_ROM_ARB_FIXED_PRIORITY_EN
          last_grant  <= win;
`endif
          rom_address <= win ? address1 : address0;
          rom_n_cs    <= 1'b0;
          rom_n_rd    <= 1'b0;
          busy        <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          rom_n_cs <= 1'b1;
          rom_n_rd <= 1'b1;
          cnt      <= 4'd0;
          state    <= WAIT;
        end
        WAIT: if (fin) begin
          if (grant) rdata1 <= dat;
          else rdata0 <= dat;
          timeout_err <= timeout_err | !rom_rdata_en;
          ack0        <= !grant;
          ack1        <= grant;
          state       <= DONE;
        end else begin
          cnt <= cnt + 4'd1;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
